// File: rtl/tm1638_frame_sequencer_pkg.sv
// Shared constants and types for the TM1638 frame sequencer.
//   - TM1638 command bytes and the display-control ON bit position
//   - step numbers for the per-frame command sequence
//   - sequencer state type
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR       = 8'hC0;
  localparam logic [7:0] CMD_DISP_CTRL  = 8'h80;
  localparam int unsigned DISP_ON_BIT   = 3;

  localparam logic [4:0] STEP_MODE   = 5'd0;
  localparam logic [4:0] STEP_DIGIT0 = 5'd1;
  localparam logic [4:0] STEP_CTRL   = 5'd17;
  localparam logic [4:0] STEP_KEYS   = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_BUSY
  } state_t;

endpackage

// File: rtl/tm1638_frame_sequencer_cmd_rom.sv
// Combinational command table: maps a frame step plus the frame snapshot
// to the SPI transaction for that step.
//   step            : 0 mode, 1..16 digit writes, 17 display control, 18 key read
//   snap_*          : display image and settings captured at frame start
//   out_data        : bytes to send, unused entries 0
//   out_count       : number of bytes to send
//   in_count        : number of bytes to read back
module tm1638_cmd_rom
  import tm1638_pkg::*;
#(
  parameter int unsigned OUT_BYTES    = 8,
  parameter int unsigned OUT_BYTES_SZ = $clog2(OUT_BYTES + 1),
  parameter int unsigned IN_BYTES_SZ  = 3
) (
  input  logic [4:0]                   step,
  input  logic [15:0][7:0]             snap_ram,
  input  logic [2:0]                   snap_brightness,
  input  logic                         snap_display_on,
  output logic [OUT_BYTES-1:0][7:0]    out_data,
  output logic [OUT_BYTES_SZ-1:0]      out_count,
  output logic [IN_BYTES_SZ-1:0]       in_count
);

  logic [3:0] digit;

  always_comb begin
    digit     = 4'(step - STEP_DIGIT0);
    out_data  = '0;
    out_count = '0;
    in_count  = '0;
    if (step == STEP_MODE) begin
      out_data[0] = CMD_DATA_FIXED;
      out_count   = OUT_BYTES_SZ'(1);
    end else if (step < STEP_CTRL) begin
      out_data[0] = CMD_ADDR | {4'h0, digit};
      out_data[1] = snap_ram[digit];
      out_count   = OUT_BYTES_SZ'(2);
    end else if (step == STEP_CTRL) begin
      out_data[0] = CMD_DISP_CTRL | (8'(snap_display_on) << DISP_ON_BIT) | {5'b0, snap_brightness};
      out_count   = OUT_BYTES_SZ'(1);
    end else if (step == STEP_KEYS) begin
      out_data[0] = CMD_READ_KEYS;
      out_count   = OUT_BYTES_SZ'(1);
      in_count    = IN_BYTES_SZ'(4);
    end
  end

endmodule

// File: rtl/tm1638_frame_sequencer.sv
// TM1638 frame sequencer: per frame sends the fixed-address mode command,
// 16 address/data writes, the display-control command, then reads the four
// key-scan bytes, handing each transaction to a 3-wire SPI controller.
//   clk, reset          : clock, synchronous active-high reset
//   enable              : frames start only while high
//   disp_ram            : segment bytes for addresses 0..15
//   brightness,display_on: display-control settings
//   keys, keys_valid    : last key-scan bytes and update pulse
//   frame_done          : end-of-frame pulse
//   spi_*               : SPI controller activate/busy interface
module tm1638_frame_sequencer
  import tm1638_pkg::*;
#(
  parameter int unsigned NUM_SELECTS  = 2,
  parameter int unsigned CS_INDEX     = 0,
  parameter int unsigned OUT_BYTES    = 8,
  parameter int unsigned IN_BYTES     = 4,
  parameter int unsigned OUT_BYTES_SZ = $clog2(OUT_BYTES + 1),
  parameter int unsigned IN_BYTES_SZ  = $clog2(IN_BYTES + 1),
  parameter int unsigned FRAME_GAP    = 50000,
  parameter int unsigned GAP_SZ       = $clog2(FRAME_GAP + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [15:0][7:0]             disp_ram,
  input  logic [2:0]                   brightness,
  input  logic                         display_on,
  output logic [3:0][7:0]              keys,
  output logic                         keys_valid,
  output logic                         frame_done,
  output logic                         spi_activate,
  output logic [NUM_SELECTS-1:0]       spi_in_cs,
  output logic [OUT_BYTES-1:0][7:0]    spi_out_data,
  output logic [OUT_BYTES_SZ-1:0]      spi_out_count,
  output logic [IN_BYTES_SZ-1:0]       spi_in_count,
  input  logic                         spi_busy,
  input  logic [IN_BYTES-1:0][7:0]     spi_in_data
);

  // FRAME_GAP=0 would give a zero-width counter; keep at least one bit.
  localparam int unsigned GAP_W = (GAP_SZ < 1) ? 1 : GAP_SZ;

  state_t            state;
  logic [4:0]        step;
  logic [GAP_W-1:0]  gap;
  logic [15:0][7:0]  snap_ram;
  logic [2:0]        snap_brightness;
  logic              snap_display_on;

  logic [OUT_BYTES-1:0][7:0] rom_out_data;
  logic [OUT_BYTES_SZ-1:0]   rom_out_count;
  logic [IN_BYTES_SZ-1:0]    rom_in_count;

  assign spi_in_cs = NUM_SELECTS'(1) << CS_INDEX;

  tm1638_cmd_rom #(
    .OUT_BYTES    (OUT_BYTES),
    .OUT_BYTES_SZ (OUT_BYTES_SZ),
    .IN_BYTES_SZ  (IN_BYTES_SZ)
  ) u_cmd_rom (
    .step            (step),
    .snap_ram        (snap_ram),
    .snap_brightness (snap_brightness),
    .snap_display_on (snap_display_on),
    .out_data        (rom_out_data),
    .out_count       (rom_out_count),
    .in_count        (rom_in_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      step            <= '0;
      gap             <= '0;
      snap_ram        <= '0;
      snap_brightness <= '0;
      snap_display_on <= 1'b0;
      spi_activate    <= 1'b0;
      spi_out_data    <= '0;
      spi_out_count   <= '0;
      spi_in_count    <= '0;
      keys            <= '0;
      keys_valid      <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      keys_valid <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gap != '0) begin
            gap <= gap - GAP_W'(1);
          end else if (enable && !spi_busy) begin
            // Snapshot so mid-frame display updates cannot tear a frame.
            snap_ram        <= disp_ram;
            snap_brightness <= brightness;
            snap_display_on <= display_on;
            step            <= STEP_MODE;
            state           <= S_LOAD;
          end
        end
        S_LOAD: begin
          spi_out_data  <= rom_out_data;
          spi_out_count <= rom_out_count;
          spi_in_count  <= rom_in_count;
          spi_activate  <= 1'b1;
          state         <= S_ISSUE;
        end
        S_ISSUE: begin
          // Controller samples activate only every half-bit time, so hold
          // the request until it acknowledges with busy.
          if (spi_busy) begin
            spi_activate <= 1'b0;
            state        <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!spi_busy) begin
            if (step == STEP_KEYS) begin
              for (int unsigned i = 0; i < 4; i++) keys[i] <= spi_in_data[i];
              keys_valid <= 1'b1;
              frame_done <= 1'b1;
              gap        <= GAP_W'(FRAME_GAP);
              state      <= S_IDLE;
            end else begin
              step  <= step + 5'd1;
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
module tb_tm1638_frame_sequencer;

  localparam int unsigned OUT_BYTES = 8;
  localparam int unsigned IN_BYTES  = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      enable = 1'b0;
  logic [15:0][7:0]          disp_ram = '0;
  logic [2:0]                brightness = '0;
  logic                      display_on = 1'b0;
  logic [3:0][7:0]           keys;
  logic                      keys_valid;
  logic                      frame_done;
  logic                      spi_activate;
  logic [1:0]                spi_in_cs;
  logic [OUT_BYTES-1:0][7:0] spi_out_data;
  logic [3:0]                spi_out_count;
  logic [2:0]                spi_in_count;
  logic                      spi_busy;
  logic [IN_BYTES-1:0][7:0]  spi_in_data;

  logic ext_busy = 1'b1;
  logic m_busy   = 1'b0;
  assign spi_busy    = ext_busy | m_busy;
  assign spi_in_data = {8'h44, 8'h00, 8'h20, 8'h01};

  tm1638_frame_sequencer #(
    .FRAME_GAP (20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .disp_ram      (disp_ram),
    .brightness    (brightness),
    .display_on    (display_on),
    .keys          (keys),
    .keys_valid    (keys_valid),
    .frame_done    (frame_done),
    .spi_activate  (spi_activate),
    .spi_in_cs     (spi_in_cs),
    .spi_out_data  (spi_out_data),
    .spi_out_count (spi_out_count),
    .spi_in_count  (spi_in_count),
    .spi_busy      (spi_busy),
    .spi_in_data   (spi_in_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_BYTES-1:0][7:0] d;
    logic [3:0]                oc;
    logic [2:0]                ic;
    int                        t;
  } txn_t;

  txn_t log_q[$];
  txn_t cur[$];

  int n_checks = 0;
  int n_fail   = 0;
  int busy_delay = 15;
  int busy_len   = 3;
  int m_phase = 0, m_cnt = 0, m_age = 0;
  int cyc = 0;
  int act_drop = 0, act_overrun = 0;
  int kv_cnt = 0, fd_cnt = 0, pulse_mis = 0, last_fd_cyc = 0;
  int fd_ref = 0;

  // SPI controller model: accepts a request, raises busy after busy_delay
  // cycles, holds it busy_len+1 cycles; also watches pulse outputs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (keys_valid) kv_cnt <= kv_cnt + 1;
    if (frame_done) begin
      fd_cnt      <= fd_cnt + 1;
      last_fd_cyc <= cyc;
    end
    if (keys_valid !== frame_done) pulse_mis <= pulse_mis + 1;
    case (m_phase)
      0: if (spi_activate && !spi_busy) begin
        log_q.push_back('{d: spi_out_data, oc: spi_out_count, ic: spi_in_count, t: cyc});
        if (busy_delay == 0) begin
          m_busy <= 1'b1; m_cnt <= busy_len; m_age <= 0; m_phase <= 2;
        end else begin
          m_cnt <= busy_delay - 1; m_phase <= 1;
        end
      end
      1: begin
        if (!spi_activate) act_drop <= act_drop + 1;
        if (m_cnt == 0) begin
          m_busy <= 1'b1; m_cnt <= busy_len; m_age <= 0; m_phase <= 2;
        end else m_cnt <= m_cnt - 1;
      end
      default: begin
        m_age <= m_age + 1;
        if (m_age >= 1 && spi_activate) act_overrun <= act_overrun + 1;
        if (m_cnt == 0) begin
          m_busy <= 1'b0; m_phase <= 0;
        end else m_cnt <= m_cnt - 1;
      end
    endcase
  end

  task automatic wait_frame(input int max_cyc, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < max_cyc && !ok) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1'b1;
      n++;
    end
    @(negedge clk);
    cur = log_q;
    log_q.delete();
    fd_ref = last_fd_cyc;
  endtask

  task automatic test_reset();
    int acts = 0;
    for (int i = 0; i < 16; i++) disp_ram[i] = 8'(i * 8'h11);
    brightness = 3'd5;
    display_on = 1'b1;
    enable     = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (spi_activate !== 1'b0) begin n_fail++; $display("FAIL rst_activate got %b want 0", spi_activate); end
    n_checks++; if (spi_out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", spi_out_data); end
    n_checks++; if (spi_out_count !== 4'd0 || spi_in_count !== 3'd0) begin n_fail++; $display("FAIL rst_counts got %0d/%0d want 0/0", spi_out_count, spi_in_count); end
    n_checks++; if (keys !== '0 || keys_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_keys got %h kv %b fd %b want 0", keys, keys_valid, frame_done); end
    n_checks++; if (spi_in_cs !== 2'b01) begin n_fail++; $display("FAIL cs got %b want 01", spi_in_cs); end
    reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (spi_activate) acts++;
    end
    n_checks++; if (acts !== 0) begin n_fail++; $display("FAIL activate_while_busy got %0d cycles want 0", acts); end
    ext_busy = 1'b0;
  endtask

  task automatic test_first_txn();
    int n = 0;
    while (log_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (log_q.size() == 0) begin
      n_fail++; $display("FAIL first_txn_timeout got none want 1");
    end else if (log_q[0].d !== 64'h44 || log_q[0].oc !== 4'd1 || log_q[0].ic !== 3'd0) begin
      n_fail++; $display("FAIL first_txn got %h/%0d/%0d want 44/1/0", log_q[0].d, log_q[0].oc, log_q[0].ic);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int bad = 0;
    wait_frame(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame1_timeout got none want frame_done"); end
    n_checks++; if (cur.size() != 19) begin n_fail++; $display("FAIL frame1_txn_count got %0d want 19", cur.size()); end
    if (cur.size() == 19) begin
      for (int i = 0; i < 16; i++)
        if (cur[i+1].d[0] !== 8'(8'hC0 + i) || cur[i+1].d[1] !== 8'(i * 8'h11) ||
            cur[i+1].d[7:2] !== '0 || cur[i+1].oc !== 4'd2 || cur[i+1].ic !== 3'd0) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL digit_writes got %0d bad want 0", bad); end
      n_checks++; if (cur[6].d[1:0] !== 16'h55C5) begin n_fail++; $display("FAIL digit5 got %h want 55c5", cur[6].d[1:0]); end
      n_checks++; if (cur[16].d[1:0] !== 16'hFFCF) begin n_fail++; $display("FAIL digit15 got %h want ffcf", cur[16].d[1:0]); end
      n_checks++; if (cur[17].d !== 64'h8D || cur[17].oc !== 4'd1 || cur[17].ic !== 3'd0) begin n_fail++; $display("FAIL disp_ctrl got %h/%0d/%0d want 8d/1/0", cur[17].d, cur[17].oc, cur[17].ic); end
      n_checks++; if (cur[18].d !== 64'h42 || cur[18].oc !== 4'd1 || cur[18].ic !== 3'd4) begin n_fail++; $display("FAIL key_read got %h/%0d/%0d want 42/1/4", cur[18].d, cur[18].oc, cur[18].ic); end
    end
    n_checks++; if (act_drop !== 0) begin n_fail++; $display("FAIL activate_early_drop got %0d want 0", act_drop); end
    n_checks++; if (act_overrun !== 0) begin n_fail++; $display("FAIL activate_overrun got %0d want 0", act_overrun); end
  endtask

  task automatic test_keys();
    n_checks++; if (keys !== {8'h44, 8'h00, 8'h20, 8'h01}) begin n_fail++; $display("FAIL keys got %h want 44002001", keys); end
    n_checks++; if (kv_cnt !== 1 || fd_cnt !== 1) begin n_fail++; $display("FAIL pulse_len got kv %0d fd %0d want 1/1", kv_cnt, fd_cnt); end
    n_checks++; if (pulse_mis !== 0) begin n_fail++; $display("FAIL pulse_align got %0d want 0", pulse_mis); end
  endtask

  task automatic test_tearing();
    bit ok;
    int n = 0;
    int prev_fd;
    busy_delay = 0;
    prev_fd = fd_ref;
    while (log_q.size() < 11 && n < 1000) begin @(negedge clk); n++; end
    disp_ram[3] = 8'hAA;
    wait_frame(1000, ok);
    n_checks++; if (!ok || cur.size() != 19) begin n_fail++; $display("FAIL frame2 got ok %b txns %0d want 1/19", ok, cur.size()); end
    if (cur.size() == 19) begin
      n_checks++; if (cur[4].d[1:0] !== 16'h33C3) begin n_fail++; $display("FAIL old_snapshot got %h want 33c3", cur[4].d[1:0]); end
      n_checks++; if (cur[0].t - prev_fd < 20 || cur[0].t - prev_fd > 30) begin n_fail++; $display("FAIL frame_gap got %0d want 20..30", cur[0].t - prev_fd); end
    end
    wait_frame(1000, ok);
    n_checks++; if (!ok || cur.size() != 19) begin n_fail++; $display("FAIL frame3 got ok %b txns %0d want 1/19", ok, cur.size()); end
    if (cur.size() == 19) begin
      n_checks++; if (cur[4].d[1:0] !== 16'hAAC3) begin n_fail++; $display("FAIL new_snapshot got %h want aac3", cur[4].d[1:0]); end
    end
  endtask

  task automatic test_enable();
    bit ok;
    int n = 0;
    int en_cyc;
    while (log_q.size() < 6 && n < 1000) begin @(negedge clk); n++; end
    enable = 1'b0;
    wait_frame(1000, ok);
    n_checks++; if (!ok || cur.size() != 19) begin n_fail++; $display("FAIL frame_after_disable got ok %b txns %0d want 1/19", ok, cur.size()); end
    repeat (60) @(negedge clk);
    n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL idle_while_disabled got %0d txns want 0", log_q.size()); end
    n_checks++; if (kv_cnt !== 4 || fd_cnt !== 4 || pulse_mis !== 0) begin n_fail++; $display("FAIL pulse_totals got kv %0d fd %0d mis %0d want 4/4/0", kv_cnt, fd_cnt, pulse_mis); end
    en_cyc = cyc;
    enable = 1'b1;
    n = 0;
    while (log_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (log_q.size() == 0) begin
      n_fail++; $display("FAIL restart_timeout got none want 1");
    end else if (log_q[0].t - en_cyc > 6 || log_q[0].t - fd_ref < 20 || log_q[0].d !== 64'h44) begin
      n_fail++; $display("FAIL restart got start %0d after en %0d after fd data %h want <=6 >=20 44", log_q[0].t - en_cyc, log_q[0].t - fd_ref, log_q[0].d);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    busy_delay = 15;
    while (!(spi_activate && m_phase == 1 && m_cnt > 5) && n < 1000) begin @(negedge clk); n++; end
    n_checks++; if (spi_activate !== 1'b1) begin n_fail++; $display("FAIL mid_setup got activate %b want 1", spi_activate); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (spi_activate !== 1'b0 || spi_out_count !== 4'd0 || spi_out_data !== '0) begin n_fail++; $display("FAIL mid_reset got act %b cnt %0d data %h want 0", spi_activate, spi_out_count, spi_out_data); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_txn();
    test_frame();
    test_keys();
    test_tearing();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
